// File: rtl/lmdpl_dualrail_unmask_rx.sv
`timescale 1ns/1ps
// lmdpl_dualrail_unmask_rx
// Receive-side sequencer for WIDTH masked dual-rail LMDPL outputs.
// The block precharges the gates and then lets them evaluate. It waits until
// every rail pair has resolved, then captures the true rails and unmasks them
// with the mask that was latched at start. A rail fault or an evaluation
// timeout aborts the transaction and leaves a sticky error flag set.
//
// Ports:
//   clk, rst          single clock; synchronous active-high reset
//   start, m_out      transaction request and its output mask (taken only when idle)
//   q_m, q_m_bar      masked true/complement rails from the gate array
//   precharge         1 = gates forced to precharge (rails low)
//   busy              transaction in flight (start acceptance until back in IDLE)
//   out_data/out_valid/out_ready   unmasked result handshake
//   err_fault         sticky: a rail pair read 11, or the rails were not low at the end of precharge
//   err_timeout       sticky: evaluation never completed
module lmdpl_dualrail_unmask_rx #(
  parameter int WIDTH        = 8,
  parameter int PRE_CYCLES   = 1,
  parameter int EVAL_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] m_out,
  input  logic [WIDTH-1:0] q_m,
  input  logic [WIDTH-1:0] q_m_bar,
  output logic             precharge,
  output logic             busy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             err_fault,
  output logic             err_timeout
);

  localparam int PW = $clog2(PRE_CYCLES + 1);
  localparam int EW = $clog2(EVAL_TIMEOUT + 1);
  localparam logic [PW-1:0] PRE_LAST  = PW'(PRE_CYCLES - 1);
  localparam logic [EW-1:0] EVAL_LAST = EW'(EVAL_TIMEOUT - 1);
  localparam logic [EW-1:0] EVAL_MAX  = EW'(EVAL_TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_EVAL, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [PW-1:0]    pre_cnt_q, pre_cnt_d;
  logic [EW-1:0]    eval_cnt_q, eval_cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             precharge_q, precharge_d;
  logic             busy_q, busy_d;
  logic             out_valid_q, out_valid_d;
  logic             err_fault_q, err_fault_d;
  logic             err_timeout_q, err_timeout_d;

  logic rail_fault, rail_done, rail_any, pre_last, eval_last;

  // Rail classification of the current sample. A pair is done when exactly
  // one rail is high; both rails high is a fault.
  assign rail_fault = |(q_m & q_m_bar);
  assign rail_done  = &(q_m ^ q_m_bar);
  assign rail_any   = |(q_m | q_m_bar);
  assign pre_last   = (pre_cnt_q == PRE_LAST);
  assign eval_last  = (eval_cnt_q == EVAL_LAST);

  // State and registered outputs. Reset puts the gates back into precharge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      mask_q        <= '0;
      pre_cnt_q     <= '0;
      eval_cnt_q    <= '0;
      out_data_q    <= '0;
      precharge_q   <= 1'b1;
      busy_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      err_fault_q   <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      pre_cnt_q     <= pre_cnt_d;
      eval_cnt_q    <= eval_cnt_d;
      out_data_q    <= out_data_d;
      precharge_q   <= precharge_d;
      busy_q        <= busy_d;
      out_valid_q   <= out_valid_d;
      err_fault_q   <= err_fault_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Next-state logic. In EVAL a fault wins over completion, and completion
  // wins over timeout. Unknown encodings fall back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_PRE;
      S_PRE:  if (pre_last) state_d = rail_any ? S_IDLE : S_EVAL;
      S_EVAL: begin
        if (rail_fault)     state_d = S_IDLE;
        else if (rail_done) state_d = S_HOLD;
        else if (eval_last) state_d = S_IDLE;
      end
      S_HOLD: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath logic. Status outputs come from the next state so
  // that they are registered and still line up with the state they describe.
  always_comb begin
    mask_d        = mask_q;
    pre_cnt_d     = pre_cnt_q;
    eval_cnt_d    = eval_cnt_q;
    out_data_d    = out_data_q;
    err_fault_d   = err_fault_q;
    err_timeout_d = err_timeout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d        = m_out;
          pre_cnt_d     = '0;
          eval_cnt_d    = '0;
          err_fault_d   = 1'b0;
          err_timeout_d = 1'b0;
        end
      end
      S_PRE: begin
        if (!pre_last)     pre_cnt_d = pre_cnt_q + 1'b1;
        else if (rail_any) err_fault_d = 1'b1;
      end
      S_EVAL: begin
        if (rail_fault) begin
          err_fault_d = 1'b1;
        end else if (rail_done) begin
          out_data_d = q_m ^ mask_q;
        end else begin
          if (eval_last) err_timeout_d = 1'b1;
          if (eval_cnt_q != EVAL_MAX) eval_cnt_d = eval_cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
    precharge_d = (state_d != S_EVAL);
    busy_d      = (state_d != S_IDLE);
    out_valid_d = (state_d == S_HOLD);
  end

  assign precharge   = precharge_q;
  assign busy        = busy_q;
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign err_fault   = err_fault_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_lmdpl_dualrail_unmask_rx.sv
`timescale 1ns/1ps
// Directed bench for lmdpl_dualrail_unmask_rx (WIDTH=8, PRE_CYCLES=1,
// EVAL_TIMEOUT=15). Expected results are built from chosen data and masks.
// They are queued when the rails are driven and popped at the output handshake.
module tb_lmdpl_dualrail_unmask_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] m_out;
  logic [7:0] q_m;
  logic [7:0] q_m_bar;
  logic       precharge;
  logic       busy;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       err_fault;
  logic       err_timeout;

  int assert_cnt = 0;
  int fail_cnt   = 0;
  logic [7:0] exp_q[$];

  lmdpl_dualrail_unmask_rx #(
    .WIDTH(8), .PRE_CYCLES(1), .EVAL_TIMEOUT(15)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .m_out(m_out),
    .q_m(q_m), .q_m_bar(q_m_bar), .precharge(precharge), .busy(busy),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .err_fault(err_fault), .err_timeout(err_timeout)
  );

  // 100 MHz free-running clock
  always #5 clk = ~clk;

  // Advance one clock edge and settle a little after it. Both sampling and driving happen here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare one observed value against the bench's expectation
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue a start with the given mask and run through precharge. The task
  // returns once the DUT is in EVAL and its next edge samples the rails.
  task automatic applyStimulus(input logic [7:0] mask);
    start = 1'b1;
    m_out = mask;
    tick();
    start = 1'b0;
    m_out = 8'($urandom);
    tick();
  endtask

  // Drive the rail pairs selected by en with the masked encoding of data. All other pairs stay pending.
  task automatic drive_rails(input logic [7:0] data, input logic [7:0] mask, input logic [7:0] en);
    logic [7:0] x;
    x = data ^ mask;
    q_m     = x & en;
    q_m_bar = ~x & en;
  endtask

  // The result must already be presented. Pop its expectation, then perform one handshake.
  task automatic wait_result(input string tag);
    logic [7:0] exp;
    checkOutput({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hxx;
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_data"}, 32'(out_data), 32'(exp));
    q_m = 8'h00;
    q_m_bar = 8'h00;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_busy_drop"}, 32'(busy), 32'd0);
    checkOutput({tag, "_data_keep"}, 32'(out_data), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; m_out = 8'h00;
    q_m = 8'h00; q_m_bar = 8'h00; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    checkOutput("rst_precharge", 32'(precharge), 32'd1);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_fault", 32'(err_fault), 32'd0);
    checkOutput("rst_timeout", 32'(err_timeout), 32'd0);

    // 1: basic transaction, mask A5, rails 99/66 -> 3C, valid by T+3
    start = 1'b1; m_out = 8'hA5;
    tick();
    start = 1'b0; m_out = 8'h00;
    checkOutput("t1_pre_busy", 32'(busy), 32'd1);
    checkOutput("t1_pre_precharge", 32'(precharge), 32'd1);
    tick();
    checkOutput("t1_eval_precharge", 32'(precharge), 32'd0);
    checkOutput("t1_eval_valid", 32'(out_valid), 32'd0);
    drive_rails(8'h3C, 8'hA5, 8'hFF);
    checkOutput("t1_rails_qm", 32'(q_m), 32'h99);
    exp_q.push_back(8'h3C);
    tick();
    checkOutput("t1_hold_precharge", 32'(precharge), 32'd1);
    wait_result("t1");

    // 2: staggered completion, bit 7 resolves in the fourth EVAL cycle
    applyStimulus(8'h12);
    drive_rails(8'h81, 8'h12, 8'h7F);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t2_not_valid", 32'(out_valid), 32'd0);
      checkOutput("t2_eval_precharge", 32'(precharge), 32'd0);
    end
    drive_rails(8'h81, 8'h12, 8'hFF);
    exp_q.push_back(8'h81);
    tick();
    checkOutput("t2_fault", 32'(err_fault), 32'd0);
    checkOutput("t2_timeout", 32'(err_timeout), 32'd0);
    wait_result("t2");

    // 3a: rail fault on bit 2 during EVAL
    applyStimulus(8'h00);
    q_m = 8'h04; q_m_bar = 8'h04;
    tick();
    q_m = 8'h00; q_m_bar = 8'h00;
    checkOutput("t3_fault_set", 32'(err_fault), 32'd1);
    checkOutput("t3_busy", 32'(busy), 32'd0);
    checkOutput("t3_no_valid", 32'(out_valid), 32'd0);
    checkOutput("t3_precharge", 32'(precharge), 32'd1);
    // 3b: the next start clears the flag; rails high at the end of PRE fault again
    start = 1'b1; m_out = 8'h55;
    tick();
    start = 1'b0;
    checkOutput("t3_fault_cleared", 32'(err_fault), 32'd0);
    checkOutput("t3_restart_busy", 32'(busy), 32'd1);
    q_m = 8'h01;
    tick();
    q_m = 8'h00;
    checkOutput("t3_pre_fault", 32'(err_fault), 32'd1);
    checkOutput("t3_pre_busy", 32'(busy), 32'd0);
    checkOutput("t3_pre_precharge", 32'(precharge), 32'd1);

    // 4: timeout after 15 pending EVAL cycles
    applyStimulus(8'hC3);
    for (int i = 0; i < 14; i++) tick();
    checkOutput("t4_still_busy", 32'(busy), 32'd1);
    checkOutput("t4_no_timeout_yet", 32'(err_timeout), 32'd0);
    tick();
    checkOutput("t4_timeout", 32'(err_timeout), 32'd1);
    checkOutput("t4_busy", 32'(busy), 32'd0);
    checkOutput("t4_precharge", 32'(precharge), 32'd1);
    checkOutput("t4_fault_clear", 32'(err_fault), 32'd0);
    drive_rails(8'h77, 8'hC3, 8'hFF);
    tick();
    tick();
    q_m = 8'h00; q_m_bar = 8'h00;
    checkOutput("t4_late_no_valid", 32'(out_valid), 32'd0);
    checkOutput("t4_late_idle", 32'(busy), 32'd0);

    // 5: backpressure with start pulsing while the result is held
    applyStimulus(8'h6B);
    drive_rails(8'h2E, 8'h6B, 8'hFF);
    exp_q.push_back(8'h2E);
    tick();
    q_m = 8'h00; q_m_bar = 8'h00;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0);
      m_out = 8'($urandom);
      tick();
      checkOutput("t5_hold_valid", 32'(out_valid), 32'd1);
      checkOutput("t5_hold_data", 32'(out_data), 32'h2E);
      checkOutput("t5_hold_busy", 32'(busy), 32'd1);
    end
    start = 1'b1;
    wait_result("t5");
    start = 1'b0;
    tick();
    checkOutput("t5_start_not_queued", 32'(busy), 32'd0);

    // 6: reset in the middle of EVAL, then a fresh transaction
    applyStimulus(8'h0F);
    drive_rails(8'h44, 8'h0F, 8'h0F);
    tick();
    checkOutput("t6_eval_precharge", 32'(precharge), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q_m = 8'h00; q_m_bar = 8'h00;
    checkOutput("t6_precharge", 32'(precharge), 32'd1);
    checkOutput("t6_busy", 32'(busy), 32'd0);
    checkOutput("t6_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_data", 32'(out_data), 32'd0);
    checkOutput("t6_fault", 32'(err_fault), 32'd0);
    checkOutput("t6_timeout", 32'(err_timeout), 32'd0);
    applyStimulus(8'hF0);
    drive_rails(8'h99, 8'hF0, 8'hFF);
    exp_q.push_back(8'h99);
    tick();
    wait_result("t6");

    checkOutput("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
